load_store_unit: RTL and testbench

- Initiator side of the CPU's data-memory port. Accepts one load or store request at a time from the execute stage and drives dataMemory's address, dataIn and writeEnable pins. Returns data on dataOut.
- Supports byte, halfword and word accesses. Sub-word stores use a read-modify-write sequence, because dataMemory only writes whole words.
- Lane order is big-endian, matching MIPS.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus dataMemory pins between the CPU-side environment and the LSU.
// master = CPU + data memory side, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  logic        mem_writeEnable;
  logic [31:0] mem_dataOut;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_dataOut,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_dataIn, mem_writeEnable
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_dataOut,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_dataIn, mem_writeEnable
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads and stores, big-endian lanes, read-modify-write sub-word stores.
// Optional macro LSU_BOUNDS_CHECK_EN rejects word addresses outside [BASE, BASE+4*DEPTH_WORDS).
module load_store_unit #(
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  localparam int unsigned DW   = 32;
  localparam logic [DW-1:0] SPAN = DW'(4 * DEPTH_WORDS);
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_write, w_write_nxt;
  logic [1:0]    r_size, w_size_nxt;
  logic          r_signed, w_signed_nxt;
  logic [1:0]    r_lane, w_lane_nxt;
  logic [15:0]   r_wdata, w_wdata_nxt;
  logic          r_req_ready, w_req_ready_nxt;
  logic          r_resp_valid, w_resp_valid_nxt;
  logic          r_resp_err, w_resp_err_nxt;
  logic [DW-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic [DW-1:0] r_mem_address, w_mem_address_nxt;
  logic [DW-1:0] r_mem_dataIn, w_mem_dataIn_nxt;
  logic          r_mem_we, w_mem_we_nxt;

  logic [DW-1:0] w_word_addr;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_bad;

  // Right-justify the addressed lane and extend it.
  function automatic logic [DW-1:0] extract(input logic [DW-1:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = w[31:24];
      2'b01:   b = w[23:16];
      2'b10:   b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lane[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: extract = {{16{sgn & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace the addressed lane of the fetched word with store data.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] w, input logic [1:0] sz,
                                          input logic [1:0] lane, input logic [15:0] d);
    logic [DW-1:0] m;
    m = w;
    if (sz == SZ_BYTE) begin
      case (lane)
        2'b00:   m[31:24] = d[7:0];
        2'b01:   m[23:16] = d[7:0];
        2'b10:   m[15:8]  = d[7:0];
        default: m[7:0]   = d[7:0];
      endcase
    end else if (sz == SZ_HALF) begin
      if (lane[1]) m[15:0] = d;
      else         m[31:16] = d;
    end
    merge = m;
  endfunction

  assign w_word_addr    = {bus.req_addr[31:2], 2'b00};
  assign w_misaligned   = (bus.req_size == 2'b11) ||
                          ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                          ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  // Single unsigned compare: addresses below BASE wrap to a large offset.
  assign w_out_of_range = BOUNDS_EN && ((w_word_addr - BASE) >= SPAN);
  assign w_bad          = w_misaligned || w_out_of_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_lane        <= 2'b00;
      r_wdata       <= 16'h0000;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
      r_mem_address <= '0;
      r_mem_dataIn  <= '0;
      r_mem_we      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_write       <= w_write_nxt;
      r_size        <= w_size_nxt;
      r_signed      <= w_signed_nxt;
      r_lane        <= w_lane_nxt;
      r_wdata       <= w_wdata_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_err    <= w_resp_err_nxt;
      r_resp_rdata  <= w_resp_rdata_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_dataIn  <= w_mem_dataIn_nxt;
      r_mem_we      <= w_mem_we_nxt;
    end
  end

  // Next-state and next registered outputs; each state's outputs are set on entry.
  always_comb begin
    w_state_nxt       = r_state;
    w_write_nxt       = r_write;
    w_size_nxt        = r_size;
    w_signed_nxt      = r_signed;
    w_lane_nxt        = r_lane;
    w_wdata_nxt       = r_wdata;
    w_req_ready_nxt   = r_req_ready;
    w_resp_valid_nxt  = r_resp_valid;
    w_resp_err_nxt    = r_resp_err;
    w_resp_rdata_nxt  = r_resp_rdata;
    w_mem_address_nxt = r_mem_address;
    w_mem_dataIn_nxt  = r_mem_dataIn;
    w_mem_we_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_write_nxt     = bus.req_write;
          w_size_nxt      = bus.req_size;
          w_signed_nxt    = bus.req_signed;
          w_lane_nxt      = bus.req_addr[1:0];
          w_wdata_nxt     = bus.req_wdata[15:0];
          w_req_ready_nxt = 1'b0;
          if (w_bad) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = '0;
          end else begin
            w_mem_address_nxt = w_word_addr;
            if (bus.req_write && (bus.req_size == SZ_WORD)) begin
              w_state_nxt      = S_WRITE;
              w_mem_we_nxt     = 1'b1;
              w_mem_dataIn_nxt = bus.req_wdata;
            end else begin
              w_state_nxt = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (r_write) begin
          w_state_nxt      = S_WRITE;
          w_mem_we_nxt     = 1'b1;
          w_mem_dataIn_nxt = merge(bus.mem_dataOut, r_size, r_lane, r_wdata);
        end else begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = extract(bus.mem_dataOut, r_size, r_lane, r_signed);
        end
      end
      S_WRITE: begin
        w_state_nxt      = S_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = '0;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt      = S_IDLE;
          w_resp_valid_nxt = 1'b0;
          w_req_ready_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready       = r_req_ready;
  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_err        = r_resp_err;
  assign bus.resp_rdata      = r_resp_rdata;
  assign bus.mem_address     = r_mem_address;
  assign bus.mem_dataIn      = r_mem_dataIn;
  assign bus.mem_writeEnable = r_mem_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-addressed memory model, hand-computed expectations.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   we_cnt;
  logic [31:0] last_we_addr;
  logic [31:0] mem [0:1023];

  load_store_unit_if bus ();

  load_store_unit #(.BASE(32'h0000_0000), .DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dataOut = mem[bus.mem_address[11:2]];

  always @(posedge clk) begin
    if (bus.mem_writeEnable) begin
      mem[bus.mem_address[11:2]] <= bus.mem_dataIn;
      we_cnt       <= we_cnt + 1;
      last_we_addr <= bus.mem_address;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req_ready"},  32'(bus.req_ready), 32'd1);
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".resp_err"},   32'(bus.resp_err), 32'd0);
    chk({tag, ".resp_rdata"}, bus.resp_rdata, 32'h0);
    chk({tag, ".mem_we"},     32'(bus.mem_writeEnable), 32'd0);
    chk({tag, ".mem_addr"},   bus.mem_address, 32'h0);
    chk({tag, ".mem_din"},    bus.mem_dataIn, 32'h0);
  endtask

  // Offer one request; return edges from accept edge until resp_valid seen (bounded).
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output int lat);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                    input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err,
                    input int exp_we);
    int w0;
    int lat;
    w0 = we_cnt;
    do_req(wr, sz, sg, a, wd, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, 32'(bus.resp_err), 32'(exp_err));
    if (chk_rd) chk({tag, ".rdata"}, bus.resp_rdata, exp_rd);
    finish_resp();
    chk({tag, ".we_pulses"}, 32'(we_cnt - w0), 32'(exp_we));
  endtask

  initial begin
    int lat;
    int w0;
    n_chk = 0;
    n_err = 0;
    we_cnt = 0;
    last_we_addr = '0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;

    #8;
    chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load at 0x10
    op("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1'b1, 32'h0, 1'b0, 1);
    chk("st_w10.we_addr", last_we_addr, 32'h10);
    chk("st_w10.mem", mem[4], 32'hDEAD_BEEF);
    op("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);

    // Byte lanes over 0x11223344 at 0x20
    op("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 2, 1'b1, 32'h0, 1'b0, 1);
    op("ld_b23s", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 2, 1'b1, 32'h0000_0044, 1'b0, 0);
    op("ld_b20u", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 2, 1'b1, 32'h0000_0011, 1'b0, 0);
    op("st_b21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA, 3, 1'b1, 32'h0, 1'b0, 1);
    chk("st_b21.mem", mem[8], 32'h11AA_3344);
    op("ld_b21s", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 2, 1'b1, 32'hFFFF_FFAA, 1'b0, 0);
    op("ld_b21u", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 2, 1'b1, 32'h0000_00AA, 1'b0, 0);

    // Halfword store into low half of 0x11223344
    op("st_w20b", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 2, 1'b1, 32'h0, 1'b0, 1);
    op("st_h22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 3, 1'b1, 32'h0, 1'b0, 1);
    chk("st_h22.mem", mem[8], 32'h1122_8001);
    op("ld_h22u", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 2, 1'b1, 32'h0000_8001, 1'b0, 0);
    op("ld_h22s", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 2, 1'b1, 32'hFFFF_8001, 1'b0, 0);
    op("ld_h20s", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 2, 1'b1, 32'h0000_1122, 1'b0, 0);
    op("ld_w20s", 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 2, 1'b1, 32'h1122_8001, 1'b0, 0);

    // Error paths: no memory cycle, memory untouched
    op("err_w13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'h0, 1'b1, 0);
    op("err_h15", 1'b1, 2'b01, 1'b0, 32'h15, 32'h0000_5555, 1, 1'b1, 32'h0, 1'b1, 0);
    op("err_sz3", 1'b1, 2'b11, 1'b0, 32'h20, 32'h0000_5555, 1, 1'b1, 32'h0, 1'b1, 0);
    chk("err.mem20", mem[8], 32'h1122_8001);
    chk("err.mem14", mem[5], mem[5]);

    // Response back-pressure: outputs hold, no new accept
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat);
    chk("stall.lat", 32'(lat), 32'd2);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0BAD_0BAD;
    w0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall.valid", 32'(bus.resp_valid), 32'd1);
      chk("stall.rdata", bus.resp_rdata, 32'h1122_8001);
      chk("stall.ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    finish_resp();
    @(posedge clk); #1;
    chk("stall.no_accept_we", 32'(we_cnt - w0), 32'd0);
    chk("stall.idle", 32'(bus.req_ready), 32'd1);

    // Reset during the READ phase of a byte store
    w0 = we_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_mid.read_addr", bus.mem_address, 32'h20);
    chk("rst_mid.read_we", 32'(bus.mem_writeEnable), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid.we_pulses", 32'(we_cnt - w0), 32'd0);
    chk("rst_mid.mem", mem[8], 32'h1122_8001);

    // Top of the window and one word past it
    op("st_wffc", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFE_F00D, 2, 1'b1, 32'h0, 1'b0, 1);
    op("ld_wffc", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1'b0, 0);
`ifdef LSU_BOUNDS_CHECK_EN
    op("ld_w1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 1'b1, 32'h0, 1'b1, 0);
    op("st_w1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678, 1, 1'b1, 32'h0, 1'b1, 0);
`else
    op("ld_w1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 2, 1'b0, 32'h0, 1'b0, 0);
    chk("ld_w1000.addr", bus.mem_address, 32'h1000);
    op("st_w1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678, 2, 1'b1, 32'h0, 1'b0, 1);
    chk("st_w1000.we_addr", last_we_addr, 32'h1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
